// File: rtl/ex_muldiv_unit_pkg.sv
// Shared mul/div opcodes, FSM state type and decode helpers.
// Imported by the ID decoder and by the EX mul/div unit.
package ex_muldiv_unit_pkg;

    localparam int SIZE_MDOP = 2;
    localparam int WIDTH     = 32;

    localparam logic [SIZE_MDOP:0] MD_OP_NONE  = 3'd0;
    localparam logic [SIZE_MDOP:0] MD_OP_MULT  = 3'd1;
    localparam logic [SIZE_MDOP:0] MD_OP_MULTU = 3'd2;
    localparam logic [SIZE_MDOP:0] MD_OP_DIV   = 3'd3;
    localparam logic [SIZE_MDOP:0] MD_OP_DIVU  = 3'd4;
    localparam logic [SIZE_MDOP:0] MD_OP_MTHI  = 3'd5;
    localparam logic [SIZE_MDOP:0] MD_OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_e;

    function automatic logic md_is_iter(
        input logic [SIZE_MDOP:0] op
    );
        return (op >= MD_OP_MULT) && (op <= MD_OP_DIVU);
    endfunction

    function automatic logic md_is_signed(
        input logic [SIZE_MDOP:0] op
    );
        return (op == MD_OP_MULT) || (op == MD_OP_DIV);
    endfunction

    function automatic logic md_is_div(
        input logic [SIZE_MDOP:0] op
    );
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_sign_fix.sv
// Conditional two's-complement negate: magnitude on the way in,
// sign restore on the way out.
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning HI/LO.
// One multiplier/quotient bit per cycle; stalls the front end.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    md_state_e          state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   rs_q;
    logic               div_q;
    logic               neg_q;
    logic               rneg_q;
    logic               div0_q;

    logic             accept;
    logic             mt_hi;
    logic             mt_lo;
    logic             last;
    logic             sgn_in;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_t;
    logic [WIDTH-1:0]   trial;
    logic               geq;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   hi_nx;
    logic [WIDTH-1:0]   lo_nx;

    always_comb begin
        accept = 1'b0;
        mt_hi  = 1'b0;
        mt_lo  = 1'b0;
        if (state == S_IDLE && start_i && !flush_i) begin
            accept = md_is_iter(op_i);
            mt_hi  = (op_i == MD_OP_MTHI);
            mt_lo  = (op_i == MD_OP_MTLO);
        end
    end

    assign sgn_in  = md_is_signed(op_i);
    assign last    = (state == S_BUSY) && (cnt == LAST);
    assign busy_o  = (state == S_BUSY);
    assign stall_o = accept || (busy_o && cnt != LAST);
    assign done_o  = last && !flush_i;

    md_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .val_i (rs_i),
        .neg_i (sgn_in & rs_i[WIDTH-1]),
        .val_o (a_mag)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .val_i (rt_i),
        .neg_i (sgn_in & rt_i[WIDTH-1]),
        .val_o (b_mag)
    );

    // acc = {partial/remainder, multiplier/dividend} for both op kinds
    always_comb begin
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        rem_t  = acc[2*WIDTH-1:WIDTH-1];
        trial  = rem_t[WIDTH-1:0] - b_q;
        geq    = (rem_t >= {1'b0, b_q});
        acc_nx = {1'b0, acc[2*WIDTH-1:1]};
        if (div_q) begin
            if (geq)
                acc_nx = {trial, acc[WIDTH-2:0], 1'b1};
            else
                acc_nx = {rem_t[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else if (acc[0]) begin
            acc_nx = {sum, acc[WIDTH-1:1]};
        end
    end

    md_sign_fix #(.WIDTH(2*WIDTH)) u_fix_p (
        .val_i (acc_nx),
        .neg_i (neg_q),
        .val_o (prod)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
        .val_i (acc_nx[WIDTH-1:0]),
        .neg_i (neg_q),
        .val_o (quo)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
        .val_i (acc_nx[2*WIDTH-1:WIDTH]),
        .neg_i (rneg_q),
        .val_o (rem)
    );

    always_comb begin
        hi_nx = prod[2*WIDTH-1:WIDTH];
        lo_nx = prod[WIDTH-1:0];
        if (div_q) begin
            hi_nx = div0_q ? rs_q : rem;
            lo_nx = div0_q ? '1 : quo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            b_q    <= '0;
            rs_q   <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            div0_q <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    unique case (1'b1)
                        accept: begin
                            state  <= S_BUSY;
                            cnt    <= '0;
                            acc    <= {{WIDTH{1'b0}}, a_mag};
                            b_q    <= b_mag;
                            rs_q   <= rs_i;
                            div_q  <= md_is_div(op_i);
                            neg_q  <= sgn_in & (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
                            rneg_q <= sgn_in & rs_i[WIDTH-1];
                            div0_q <= (rt_i == '0);
                        end
                        mt_hi:   hi_o <= rs_i;
                        mt_lo:   lo_o <= rs_i;
                        default: ;
                    endcase
                end
                S_BUSY: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (last) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        hi_o  <= hi_nx;
                        lo_o  <= lo_nx;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        acc <= acc_nx;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed cases plus
// random ops against an arithmetic reference model.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs_i;
    logic [31:0] rt_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic        pend = 1'b0;

    ex_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .op_i    (op_i),
        .rs_i    (rs_i),
        .rt_i    (rt_i),
        .flush_i (flush_i),
        .stall_o (stall_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain MIPS HI/LO semantics, returns {hi, lo}
    function automatic logic [63:0] ref_md(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa;
        longint sb;
        longint p;
        int     q;
        int     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin
                p = sa * sb;
                return 64'(p);
            end
            3'd2: return {32'b0, a} * {32'b0, b};
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {32'h0, 32'h8000_0000};
                q = int'(sa / sb);
                r = int'(sa % sb);
                return {r, q};
            end
            3'd4: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Monitor: result visible the cycle after the done pulse
    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'h1, 64'h0);
            end else begin
                chk("result_hilo", {hi_o, lo_o}, exp_q.pop_front());
            end
        end
        if (done_o) pend = 1'b1;
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int st;
        bit got;
        st  = 0;
        got = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b1;
        op_i    = op;
        rs_i    = a;
        rt_i    = b;
        exp_q.push_back(exp);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall_o) st++;
            if (done_o) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", 64'(got), 64'h1);
        chk("stall_cycles", 64'(st), 64'd32);
        if (!got) void'(exp_q.pop_back());
        @(posedge clk); #1;
        start_i = 1'b0;
        op_i    = 3'd0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n   = 1'b0;
        start_i = 1'b0;
        op_i    = 3'd0;
        rs_i    = '0;
        rt_i    = '0;
        flush_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stall", 64'(stall_o), 64'h0);
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_done", 64'(done_o), 64'h0);
        chk("rst_hilo", {hi_o, lo_o}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(3'd4, 32'd100, 32'd7, {32'd2, 32'd14});
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op(3'd3, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF);
        run_op(3'd4, 32'h8000_0005, 32'd0, 64'h8000_0005_FFFF_FFFF);

        // MTHI then MTLO back to back
        @(posedge clk); #1;
        start_i = 1'b1;
        op_i    = 3'd5;
        rs_i    = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("mthi_stall", 64'(stall_o), 64'h0);
        @(posedge clk); #1;
        op_i = 3'd6;
        rs_i = 32'h5A5A_5A5A;
        @(negedge clk);
        chk("mthi_hi", 64'(hi_o), 64'hA5A5_A5A5);
        chk("mtlo_stall", 64'(stall_o | busy_o), 64'h0);
        @(posedge clk); #1;
        start_i = 1'b0;
        op_i    = 3'd0;
        @(negedge clk);
        chk("mtlo_lo", 64'(lo_o), 64'h5A5A_5A5A);

        // flush in IDLE suppresses MTHI and acceptance
        @(posedge clk); #1;
        start_i = 1'b1;
        op_i    = 3'd5;
        rs_i    = 32'h1111_1111;
        flush_i = 1'b1;
        @(posedge clk); #1;
        op_i = 3'd1;
        @(negedge clk);
        chk("idle_flush_mt", {hi_o, lo_o}, 64'hA5A5_A5A5_5A5A_5A5A);
        chk("idle_flush_stall", 64'(stall_o), 64'h0);
        @(posedge clk); #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        chk("idle_flush_busy", 64'(busy_o), 64'h0);

        // flush at cnt=10
        @(posedge clk); #1;
        start_i = 1'b1;
        op_i    = 3'd1;
        rs_i    = 32'd1234;
        rt_i    = 32'd77;
        repeat (11) @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        chk("flush_busy_before", 64'(busy_o), 64'h1);
        chk("flush_no_done", 64'(done_o), 64'h0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        chk("flush_idle", 64'({busy_o, stall_o}), 64'h0);
        chk("flush_hilo", {hi_o, lo_o}, 64'hA5A5_A5A5_5A5A_5A5A);

        // flush on the commit cycle: no write, no done
        @(posedge clk); #1;
        start_i = 1'b1;
        op_i    = 3'd4;
        rs_i    = 32'd500;
        rt_i    = 32'd3;
        repeat (32) @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        chk("cflush_stall", 64'(stall_o), 64'h0);
        chk("cflush_no_done", 64'(done_o), 64'h0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("cflush_hilo", {hi_o, lo_o}, 64'hA5A5_A5A5_5A5A_5A5A);
        chk("cflush_busy", 64'(busy_o), 64'h0);

        // reset mid-operation
        @(posedge clk); #1;
        start_i = 1'b1;
        op_i    = 3'd2;
        rs_i    = 32'hDEAD_BEEF;
        rt_i    = 32'h1234_5678;
        repeat (6) @(posedge clk);
        #1;
        start_i = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("mrst_busy", 64'({busy_o, stall_o}), 64'h0);
        chk("mrst_hilo", {hi_o, lo_o}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int n = 0; n < 24; n++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if (n == 5) begin
                rop = 3'd3;
                ra  = 32'h8000_0000;
                rb  = 32'hFFFF_FFFF;
            end
            run_op(rop, ra, rb, ref_md(rop, ra, rb));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- EX-stage multiply/divide unit that consumes the ID_EX register's operand outputs (Reg_data_1_out and Reg_data_2_out) plus a decoded mul/div opcode.
- Runs MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and owns the architectural HI/LO registers.
- Asserts a stall that freezes PC, IF_ID and ID_EX while an operation is in flight.
- MTHI/MTLO write HI/LO directly. MFHI/MFLO read hi_o/lo_o combinationally in EX.

Parameters:
- WIDTH, 32, operand width. HI/LO are each WIDTH bits.
- CNT_W, 5, iteration counter width. Must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  ID_EX holds a valid mul/div-class instruction
- op_i  in  3  opcode: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
- rs_i  in  WIDTH  operand A (Reg_data_1_out)
- rt_i  in  WIDTH  operand B (Reg_data_2_out)
- flush_i  in  1  synchronous abort (branch/jump squash of the instruction in EX)
- stall_o  out  1  freeze PC/IF_ID/ID_EX this cycle
- busy_o  out  1  FSM in BUSY
- done_o  out  1  one-cycle pulse on the commit edge's cycle
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, hi_o=0, lo_o=0, all working registers=0. Outputs read stall_o=0, busy_o=0, done_o=0.
- States: IDLE, BUSY.
- IDLE with start_i=1, op in 1..4, flush_i=0 (acceptance):
  - Latch the operands.
  - Signed ops record the sign flags and latch magnitudes |rs|, |rt|. Unsigned ops latch operands as-is.
  - Go to BUSY with cnt=0.
  - stall_o=1 in the acceptance cycle.
- MULT/MULTU: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
- DIV/DIVU: restoring division, one quotient bit per cycle.
- BUSY:
  - cnt increments each cycle.
  - stall_o=1 while cnt<WIDTH-1.
  - At cnt==WIDTH-1: stall_o=0 and done_o=1. The final step completes and HI/LO are written at the clock edge ending that cycle, and the state returns to IDLE. ID_EX advances on that same edge.
- Timing: stall is high for exactly WIDTH cycles (33 cycles total EX occupancy). HI/LO are visible the cycle after done_o.
- Result mapping:
  - MULT/MULTU: HI = product[2W-1:W], LO = product[W-1:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
- Signed fix-up:
  - Product negated if sign(rs)^sign(rt).
  - Quotient negated if sign(rs)^sign(rt).
  - Remainder takes the sign of rs.
- Divide by zero (rt=0): no trap, full latency still taken. LO=all ones, HI=rs (original value, not magnitude). Applies to both DIV and DIVU.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO in IDLE with start_i=1: HI (or LO) <= rs_i at the edge. No stall, no done_o, state stays IDLE.
- op NONE, or start_i=0: no effect.
- start_i in BUSY: ignored. ID_EX is stalled and re-presents the same instruction, so it must not restart.
- flush_i:
  - In BUSY: next state IDLE, HI/LO unchanged, no done_o.
  - In IDLE: suppresses acceptance and MTHI/MTLO writes.
  - flush_i and the commit cycle together: flush wins, no write.
- Reset mid-operation: immediate abort, HI/LO cleared to 0.
- busy_o = (state==BUSY).

Decomposition:
- Shared include (the codebase parameter-macro file):
  - MD_OP_NONE..MD_OP_MTLO opcode macros
  - SIZE_MDOP = 2 (op_i width minus 1)
  - WIDTH default 32
- ID-stage decode uses these same macros to drive op_i through ID_EX.
- One natural sub-module: md_sign_fix (combinational abs-in / negate-out helper), instantiated for the input magnitudes and the result fix-up.
- The FSM, counter and datapath stay in ex_muldiv_unit.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> stall_o high 32 cycles, done_o pulse on 33rd EX cycle; then hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1.
- DIVU rs=100, rt=7 -> lo_o=14, hi_o=2. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- DIV rs=0x1234, rt=0 -> full latency, lo_o=0xFFFFFFFF, hi_o=0x1234.
- MTHI rs=0xA5A5A5A5, then MTLO rs=0x5A5A5A5A on the next cycle -> no stall, hi_o/lo_o updated one cycle after each.
- Start MULT with HI/LO=0xA5A5A5A5/0x5A5A5A5A, assert flush_i at cnt=10 -> IDLE next cycle, busy_o=0, no done_o, HI/LO unchanged. Repeat with rst_n pulsed low mid-op -> immediate IDLE, hi_o=lo_o=0.
